max_inst_issue: RTL and testbench

- Instruction-side producer for the max pooling path.
- Accepts block-max commands: source register bases A and B, destination base, and length.
- Expands each command into a stream of 12-bit max instructions {src1[3:0], src2[3:0], dst[3:0]}.
- Delivers them over a valid/ready handshake to the max decode stage. It is the emitting end of the inst interface that max decode consumes.

---
 rtl/max_isa_pkg.sv | 50 +++++
 rtl/max_inst_issue_if.sv | 31 +++
 rtl/max_cmd_fifo.sv | 71 +++++++
 rtl/max_inst_issue.sv | 201 ++++++++++++++++++++
 tb/tb_max_inst_issue.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/max_isa_pkg.sv
// -----------------------------------------------------------------------------
// max_isa_pkg
// Shared definitions for the max-pooling instruction path: register index
// width, instruction word layout, the command record carried through the
// command FIFO, and the issue FSM state type.
//
// Configuration macro: MAX_ISSUE_STRIDE_EN adds a 2-bit stride field to each
// command (index step = stride + 1). Without it the step is fixed at 1.
// -----------------------------------------------------------------------------
package max_isa_pkg;

    localparam int REG_AW = 4;
    localparam int INST_W = 3 * REG_AW;

    // Field positions inside the instruction word: {src1, src2, dst}.
    localparam int SRC1_MSB = 3 * REG_AW - 1;
    localparam int SRC1_LSB = 2 * REG_AW;
    localparam int SRC2_MSB = 2 * REG_AW - 1;
    localparam int SRC2_LSB = REG_AW;
    localparam int DST_MSB  = REG_AW - 1;
    localparam int DST_LSB  = 0;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef struct packed {
        reg_idx_t   src1;
        reg_idx_t   src2;
        reg_idx_t   dst;
        reg_idx_t   len;     // instruction count minus one
`ifdef MAX_ISSUE_STRIDE_EN
        logic [1:0] stride;  // index step minus one
`endif
    } max_cmd_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } issue_state_e;

    function automatic inst_t pack_inst(reg_idx_t s1, reg_idx_t s2, reg_idx_t d);
        inst_t w;
        w                    = '0;
        w[SRC1_MSB:SRC1_LSB] = s1;
        w[SRC2_MSB:SRC2_LSB] = s2;
        w[DST_MSB:DST_LSB]   = d;
        return w;
    endfunction

endpackage

// File: rtl/max_inst_issue_if.sv
// -----------------------------------------------------------------------------
// max_inst_issue_if
// Instruction channel between the max issue stage (master) and the max decode
// stage (slave).
//   inst_valid  master->slave  instruction present
//   inst_ready  slave->master  decode accepts the instruction
//   inst        master->slave  {src1, src2, dst}, src1 in the MSBs
//   inst_last   master->slave  final instruction of the current command
// -----------------------------------------------------------------------------
interface max_inst_issue_if;

    logic                 inst_valid;
    logic                 inst_ready;
    max_isa_pkg::inst_t   inst;
    logic                 inst_last;

    modport master (
        output inst_valid,
        output inst,
        output inst_last,
        input  inst_ready
    );

    modport slave (
        input  inst_valid,
        input  inst,
        input  inst_last,
        output inst_ready
    );

endinterface

// File: rtl/max_cmd_fifo.sv
// -----------------------------------------------------------------------------
// max_cmd_fifo
// Synchronous command FIFO holding max_cmd_t records.
//   clk, rst    clock, synchronous active-high reset
//   push        write push_data (ignored when full)
//   push_data   command to store
//   pop         drop the head entry (ignored when empty)
//   pop_data    head entry, valid whenever !empty
//   full/empty  occupancy flags
// DEPTH must be a power of two and at least 2.
// Configuration macro MAX_ISSUE_STRIDE_EN widens the entry via max_cmd_t.
// -----------------------------------------------------------------------------
module max_cmd_fifo
    import max_isa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  max_cmd_t push_data,
    input  logic     pop,
    output max_cmd_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    max_cmd_t    mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: combinational processes use blocking '=', clocked processes use
    // non-blocking '<=' so every flop samples pre-edge values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define
    // which entries are meaningful, and a reset-free array maps onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/max_inst_issue.sv
// -----------------------------------------------------------------------------
// max_inst_issue
// Instruction-side producer for the max pooling path. Buffers block-max
// commands in a small FIFO and expands each into len+1 instructions
// {src1, src2, dst}, advancing all three indices by STEP (mod 2^REG_AW) per
// accepted instruction. Commands chain with no bubble between them.
//   clk, rst        clock, synchronous active-high reset
//   cmd_valid/ready command handshake (cmd_ready = FIFO not full)
//   cmd_src1/src2   operand base registers
//   cmd_dst         destination base register
//   cmd_len         instruction count minus one
//   cmd_stride      (MAX_ISSUE_STRIDE_EN only) STEP minus one
//   inst_if         master side of the instruction channel to max decode
//   busy            FSM active or FIFO non-empty
//   issued_cnt      completed instruction handshakes, wraps
// REG_AW comes from max_isa_pkg. Configuration macro: MAX_ISSUE_STRIDE_EN.
// -----------------------------------------------------------------------------
module max_inst_issue
    import max_isa_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  reg_idx_t            cmd_src1,
    input  reg_idx_t            cmd_src2,
    input  reg_idx_t            cmd_dst,
    input  reg_idx_t            cmd_len,
`ifdef MAX_ISSUE_STRIDE_EN
    input  logic [1:0]          cmd_stride,
`endif
    max_inst_issue_if.master    inst_if,
    output logic                busy,
    output logic [CNT_W-1:0]    issued_cnt
);

    max_cmd_t     push_cmd;
    max_cmd_t     head_cmd;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_push;
    logic         fifo_pop;

    issue_state_e state_q, state_d;
    reg_idx_t     s1_q, s1_d;
    reg_idx_t     s2_q, s2_d;
    reg_idx_t     d_q, d_d;
    reg_idx_t     rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef MAX_ISSUE_STRIDE_EN
    logic [1:0]   stride_q, stride_d;
`endif

    reg_idx_t     step;
    logic         inst_hs;
    logic         load;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    always_comb begin
        push_cmd        = '0;
        push_cmd.src1   = cmd_src1;
        push_cmd.src2   = cmd_src2;
        push_cmd.dst    = cmd_dst;
        push_cmd.len    = cmd_len;
`ifdef MAX_ISSUE_STRIDE_EN
        push_cmd.stride = cmd_stride;
`endif
    end

    // Ready depends only on the registered full flag: no same-cycle bypass.
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    max_cmd_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef MAX_ISSUE_STRIDE_EN
    assign step = {{(REG_AW-2){1'b0}}, stride_q} + reg_idx_t'(1);
`else
    assign step = reg_idx_t'(1);
`endif

    assign inst_hs = (state_q == ST_ISSUE) && inst_if.inst_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            s1_q     <= '0;
            s2_q     <= '0;
            d_q      <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
`ifdef MAX_ISSUE_STRIDE_EN
            stride_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            d_q      <= d_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
`ifdef MAX_ISSUE_STRIDE_EN
            stride_q <= stride_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        d_d      = d_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        fifo_pop = 1'b0;
`ifdef MAX_ISSUE_STRIDE_EN
        stride_d = stride_q;
`endif

        if (inst_hs) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (inst_hs) begin
                    if (rem_q != '0) begin
                        s1_d  = s1_q + step;
                        s2_d  = s2_q + step;
                        d_d   = d_q + step;
                        rem_d = rem_q - reg_idx_t'(1);
                    end else if (!fifo_empty) begin
                        // Chain straight into the next command, no bubble.
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            fifo_pop = 1'b1;
            s1_d     = head_cmd.src1;
            s2_d     = head_cmd.src2;
            d_d      = head_cmd.dst;
            rem_d    = head_cmd.len;
`ifdef MAX_ISSUE_STRIDE_EN
            stride_d = head_cmd.stride;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        inst_if.inst_valid = 1'b0;
        inst_if.inst       = '0;
        inst_if.inst_last  = 1'b0;
        if (state_q == ST_ISSUE) begin
            inst_if.inst_valid = 1'b1;
            inst_if.inst       = pack_inst(s1_q, s2_q, d_q);
            inst_if.inst_last  = (rem_q == '0);
        end
    end

    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_max_inst_issue.sv
// -----------------------------------------------------------------------------
// tb_max_inst_issue
// Directed stimulus with hand-computed expected instruction words. The
// stimulus thread pushes expected {inst, last} pairs into a scoreboard queue;
// a monitor on the falling edge pops and compares on every inst handshake and
// also checks that a stalled instruction holds steady.
// -----------------------------------------------------------------------------
module tb_max_inst_issue;
    import max_isa_pkg::*;

    typedef struct {
        logic [11:0] inst;
        logic        last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    reg_idx_t   cmd_src1;
    reg_idx_t   cmd_src2;
    reg_idx_t   cmd_dst;
    reg_idx_t   cmd_len;
`ifdef MAX_ISSUE_STRIDE_EN
    logic [1:0] cmd_stride;
`endif
    logic       busy;
    logic [15:0] issued_cnt;

    max_inst_issue_if inst_if ();

    max_inst_issue #(
        .FIFO_DEPTH (4),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_src1   (cmd_src1),
        .cmd_src2   (cmd_src2),
        .cmd_dst    (cmd_dst),
        .cmd_len    (cmd_len),
`ifdef MAX_ISSUE_STRIDE_EN
        .cmd_stride (cmd_stride),
`endif
        .inst_if    (inst_if),
        .busy       (busy),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   tests = 0;
    int   fails = 0;
    exp_t sb [$];
    int   hs_cyc [$];
    int   hs_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_inst(input logic [11:0] inst, input logic last);
        exp_t e;
        e.inst = inst;
        e.last = last;
        sb.push_back(e);
    endtask

    // Offers one command and returns one cycle after it was accepted, with
    // cmd_valid still high so calls can be chained back to back.
    task automatic send_cmd(input logic [3:0] s1, input logic [3:0] s2,
                            input logic [3:0] d, input logic [3:0] len,
                            input logic [1:0] stride);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            cmd_valid = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL send_cmd_timeout: cmd_ready stuck at 0");
        end
        cmd_src1  = s1;
        cmd_src2  = s2;
        cmd_dst   = d;
        cmd_len   = len;
`ifdef MAX_ISSUE_STRIDE_EN
        cmd_stride = stride;
`else
        if (stride != 2'd0) $display("note: stride ignored in this build");
`endif
        cmd_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name, output int idle_cyc);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        idle_cyc = cyc;
        check({name, "_drained"}, (n < 300) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_n < target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_hs_reached", (hs_n >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic check_consec(input string name, input int first, input int n);
        for (int k = 1; k < n; k++)
            check(name, hs_cyc[first+k] - hs_cyc[first], k);
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    logic        mon_stalled = 1'b0;
    logic [11:0] mon_held;
    logic        mon_held_last;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_stalled = 1'b0;
            end else begin
                if (mon_stalled && inst_if.inst_valid) begin
                    check("stall_inst_stable", inst_if.inst, mon_held);
                    check("stall_last_stable", inst_if.inst_last, mon_held_last);
                end
                if (inst_if.inst_valid && inst_if.inst_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_inst: got inst 0x%0h, expected no instruction",
                                 inst_if.inst);
                    end else begin
                        e = sb.pop_front();
                        check("inst_word", inst_if.inst, e.inst);
                        check("inst_last", inst_if.inst_last, e.last);
                    end
                    hs_cyc.push_back(cyc);
                    hs_n++;
                end
                mon_stalled   = inst_if.inst_valid && !inst_if.inst_ready;
                mon_held      = inst_if.inst;
                mon_held_last = inst_if.inst_last;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stimulus
        int base;
        int idle_cyc;
        int vcount;

        rst                = 1'b1;
        cmd_valid          = 1'b0;
        cmd_src1           = '0;
        cmd_src2           = '0;
        cmd_dst            = '0;
        cmd_len            = '0;
`ifdef MAX_ISSUE_STRIDE_EN
        cmd_stride         = '0;
`endif
        inst_if.inst_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_inst_valid", inst_if.inst_valid, 1'b0);
        check("rst_inst",       inst_if.inst, 12'h000);
        check("rst_inst_last",  inst_if.inst_last, 1'b0);
        check("rst_issued_cnt", issued_cnt, 16'd0);
        check("rst_busy",       busy, 1'b0);
        check("rst_cmd_ready",  cmd_ready, 1'b1);

        // 1) Single command, consumer always ready; inst_valid first high
        // two edges after acceptance, busy falls one cycle after last handshake.
        base = hs_n;
        expect_inst(12'h280, 1'b0);
        expect_inst(12'h391, 1'b0);
        expect_inst(12'h4A2, 1'b1);
        send_cmd(4'd2, 4'd8, 4'd0, 4'd2, 2'd0);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("lat_valid_e1", inst_if.inst_valid, 1'b0);
        @(negedge clk);
        check("lat_valid_e2", inst_if.inst_valid, 1'b1);
        drain("single", idle_cyc);
        check_consec("single_consec", base, 3);
        check("single_busy_fall", idle_cyc - hs_cyc[base+2], 1);
        check("single_cnt", issued_cnt, 16'd3);

        // 2) Index wrap 15 -> 0.
        base = hs_n;
        expect_inst(12'hEFD, 1'b0);
        expect_inst(12'hF0E, 1'b0);
        expect_inst(12'h01F, 1'b0);
        expect_inst(12'h120, 1'b1);
        send_cmd(4'd14, 4'd15, 4'd13, 4'd3, 2'd0);
        cmd_valid = 1'b0;
        drain("wrap", idle_cyc);
        check_consec("wrap_consec", base, 4);
        check("wrap_cnt", issued_cnt, 16'd7);

        // 3) Backpressure: 5 stalled cycles after the second instruction.
        base = hs_n;
        expect_inst(12'h123, 1'b0);
        expect_inst(12'h234, 1'b0);
        expect_inst(12'h345, 1'b0);
        expect_inst(12'h456, 1'b0);
        expect_inst(12'h567, 1'b0);
        expect_inst(12'h678, 1'b1);
        send_cmd(4'd1, 4'd2, 4'd3, 4'd5, 2'd0);
        cmd_valid = 1'b0;
        wait_hs(base + 2);
        inst_if.inst_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("bp_no_hs_while_stalled", hs_n - base, 2);
        check("bp_held_inst", inst_if.inst, 12'h345);
        inst_if.inst_ready = 1'b1;
        drain("bp", idle_cyc);
        check("bp_cnt", issued_cnt, 16'd13);

        // 4) Back-to-back len-0 commands with the consumer stalled. The first
        // command moves into the working registers, so the 4-entry FIFO
        // fills on the fifth acceptance.
        inst_if.inst_ready = 1'b0;
        base = hs_n;
        expect_inst(12'h123, 1'b1);
        expect_inst(12'h456, 1'b1);
        expect_inst(12'h789, 1'b1);
        expect_inst(12'hABC, 1'b1);
        expect_inst(12'hDEF, 1'b1);
        send_cmd(4'h1, 4'h2, 4'h3, 4'd0, 2'd0);
        send_cmd(4'h4, 4'h5, 4'h6, 4'd0, 2'd0);
        send_cmd(4'h7, 4'h8, 4'h9, 4'd0, 2'd0);
        send_cmd(4'hA, 4'hB, 4'hC, 4'd0, 2'd0);
        check("b2b_ready_after_4", cmd_ready, 1'b1);
        send_cmd(4'hD, 4'hE, 4'hF, 4'd0, 2'd0);
        check("b2b_ready_after_5", cmd_ready, 1'b0);
        // A sixth command offered while full must be refused.
        cmd_src1 = 4'hF; cmd_src2 = 4'hF; cmd_dst = 4'hF; cmd_len = 4'd0;
        @(posedge clk); #1;
        check("b2b_ready_held_full", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        inst_if.inst_ready = 1'b1;
        drain("b2b", idle_cyc);
        check_consec("b2b_consec", base, 5);
        check("b2b_cnt", issued_cnt, 16'd18);

`ifdef MAX_ISSUE_STRIDE_EN
        // Stride 3 -> step 4 on every index.
        expect_inst(12'h048, 1'b0);
        expect_inst(12'h48C, 1'b0);
        expect_inst(12'h8C0, 1'b1);
        send_cmd(4'd0, 4'd4, 4'd8, 4'd2, 2'd3);
        cmd_valid = 1'b0;
        drain("stride", idle_cyc);
`endif

        // 5) Reset mid-command with rem=5.
        base = hs_n;
        expect_inst(12'h000, 1'b0);
        expect_inst(12'h111, 1'b0);
        expect_inst(12'h222, 1'b0);
        expect_inst(12'h333, 1'b0);
        send_cmd(4'd0, 4'd0, 4'd0, 4'd9, 2'd0);
        cmd_valid = 1'b0;
        wait_hs(base + 4);
        inst_if.inst_ready = 1'b0;
        check("mid_inst_before_rst", inst_if.inst, 12'h444);
        check("mid_last_before_rst", inst_if.inst_last, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_inst_valid", inst_if.inst_valid, 1'b0);
        check("mid_rst_cnt",        issued_cnt, 16'd0);
        check("mid_rst_cmd_ready",  cmd_ready, 1'b1);
        check("mid_rst_busy",       busy, 1'b0);
        rst = 1'b0;
        sb.delete();
        inst_if.inst_ready = 1'b1;
        vcount = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (inst_if.inst_valid) vcount++;
        end
        check("post_rst_no_inst", vcount, 0);
        check("post_rst_cnt", issued_cnt, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
